// File: rtl/trap_seq_if.sv
// trap_seq_if: trap-side CSR port between the trap sequencer and the CSR unit.
// rdata is a combinational read of addr in the same cycle.
interface trap_seq_if;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/trap_seq.sv
// trap_seq: trap entry / mret sequencer driving the CSR unit's trap port.
// Writes epc/cause/tval/mstatus then redirects fetch; retries writes that lose to an idex CSR write.
module trap_seq #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hx_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_next_i,
    input  logic [31:0] inst_i,
    input  logic        illegal_i,
    input  logic        ebreak_i,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic        ex_irq_i,
    input  logic        soft_irq_i,
    input  logic        tcmp_irq_i,
    input  logic        mstatus_mie_i,
    input  logic        idex_csr_we_i,
    trap_seq_if.master  csr,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, JUMP, R_STAT, R_JUMP} state_t;
    state_t      r_state;
    logic [31:0] r_epc, r_cause, r_tval;
    logic        w_irq, w_accept, w_wr, w_vec, w_adv;
    logic [4:0]  w_code;
    logic [31:0] w_base;
    assign w_irq    = hx_valid_i & mstatus_mie_i & (ex_irq_i | soft_irq_i | tcmp_irq_i);
    assign w_code   = ex_irq_i ? 5'd11 : soft_irq_i ? 5'd3 : 5'd7;
    assign w_accept = rst_n & (r_state == IDLE) & (illegal_i | ebreak_i | ecall_i | mret_i | w_irq);
    assign w_wr     = r_state inside {W_EPC, W_CAUSE, W_TVAL, W_STAT, R_STAT};
    assign w_adv    = ~idex_csr_we_i;
    assign w_base   = {csr.rdata[31:2], 2'b00};
    // r_cause[31] marks an interrupt, the only case that may use the vector table
    assign w_vec    = VECTORED_EN & (csr.rdata[1:0] == 2'b01) & r_cause[31];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_epc   <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (illegal_i) begin
                        r_state <= W_EPC;
                        r_cause <= 32'd2;
                        r_epc   <= pc_i;
                        r_tval  <= inst_i;
                    end else if (ebreak_i) begin
                        r_state <= W_EPC;
                        r_cause <= 32'd3;
                        r_epc   <= pc_i;
                        r_tval  <= pc_i;
                    end else if (ecall_i) begin
                        r_state <= W_EPC;
                        r_cause <= 32'd11;
                        r_epc   <= pc_i;
                        r_tval  <= '0;
                    end else if (mret_i) begin
                        r_state <= R_STAT;
                    end else if (w_irq) begin
                        r_state <= W_EPC;
                        r_cause <= {1'b1, 26'd0, w_code};
                        r_epc   <= pc_next_i;
                        r_tval  <= '0;
                    end
                end
                W_EPC:   if (w_adv) r_state <= W_CAUSE;
                W_CAUSE: if (w_adv) r_state <= W_TVAL;
                W_TVAL:  if (w_adv) r_state <= W_STAT;
                W_STAT:  if (w_adv) r_state <= JUMP;
                R_STAT:  if (w_adv) r_state <= R_JUMP;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign csr.we = w_wr & w_adv;
    always_comb begin
        csr.addr = (r_state == W_EPC || r_state == R_JUMP) ? 12'h341 :
                   (r_state == W_CAUSE)                    ? 12'h342 :
                   (r_state == W_TVAL)                     ? 12'h343 :
                   (r_state == W_STAT || r_state == R_STAT) ? 12'h300 :
                   (r_state == JUMP)                       ? 12'h305 : 12'h000;
        csr.wdata = (r_state == W_EPC)   ? r_epc :
                    (r_state == W_CAUSE) ? r_cause :
                    (r_state == W_TVAL)  ? r_tval :
                    (r_state == W_STAT)  ? {csr.rdata[31:8], csr.rdata[3], csr.rdata[6:4], 1'b0, csr.rdata[2:0]} :
                    (r_state == R_STAT)  ? {csr.rdata[31:8], 1'b1, csr.rdata[6:4], csr.rdata[7], csr.rdata[2:0]} :
                    32'd0;
        jump_addr_o = (r_state == JUMP)   ? w_base + (w_vec ? {25'd0, r_cause[4:0], 2'b00} : 32'd0) :
                      (r_state == R_JUMP) ? csr.rdata : 32'd0;
    end
    assign hold_o = w_accept | (r_state != IDLE);
    assign jump_o = (r_state == JUMP) | (r_state == R_JUMP);
endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: scoreboard bench for trap_seq with a behavioural CSR unit and reference model.
// Expected CSR writes and jumps are queued at issue time; a monitor pops them as the DUT emits them.
module tb_trap_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hx_valid_i = 0, illegal_i = 0, ebreak_i = 0, ecall_i = 0, mret_i = 0;
    logic        ex_irq_i = 0, soft_irq_i = 0, tcmp_irq_i = 0, mstatus_mie_i = 0, idex_csr_we_i = 0;
    logic [31:0] pc_i = 0, pc_next_i = 0, inst_i = 0;
    logic        hold_o, jump_o;
    logic [31:0] jump_addr_o;
    logic        cfg_we = 0;
    logic [11:0] cfg_addr = 0;
    logic [31:0] cfg_data = 0;
    logic [31:0] e_mstatus, e_mtvec, e_mepc, e_mcause, e_mtval;
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    int vec = 0, err = 0;
    typedef struct packed {logic jmp; logic [11:0] addr; logic [31:0] data;} ev_t;
    ev_t sb[$];
    always #5 clk = ~clk;
    trap_seq_if bus();
    trap_seq #(.VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hx_valid_i(hx_valid_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
        .inst_i(inst_i), .illegal_i(illegal_i), .ebreak_i(ebreak_i), .ecall_i(ecall_i),
        .mret_i(mret_i), .ex_irq_i(ex_irq_i), .soft_irq_i(soft_irq_i), .tcmp_irq_i(tcmp_irq_i),
        .mstatus_mie_i(mstatus_mie_i), .idex_csr_we_i(idex_csr_we_i), .csr(bus),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );
    // CSR unit stand-in: combinational read, write on the clock edge
    always_comb
        bus.rdata = (bus.addr == 12'h300) ? e_mstatus : (bus.addr == 12'h305) ? e_mtvec :
                    (bus.addr == 12'h341) ? e_mepc : (bus.addr == 12'h342) ? e_mcause :
                    (bus.addr == 12'h343) ? e_mtval : 32'd0;
    always @(posedge clk) begin
        if (cfg_we || bus.we) begin
            case (cfg_we ? cfg_addr : bus.addr)
                12'h300: e_mstatus <= cfg_we ? cfg_data : bus.wdata;
                12'h305: e_mtvec   <= cfg_we ? cfg_data : bus.wdata;
                12'h341: e_mepc    <= cfg_we ? cfg_data : bus.wdata;
                12'h342: e_mcause  <= cfg_we ? cfg_data : bus.wdata;
                12'h343: e_mtval   <= cfg_we ? cfg_data : bus.wdata;
                default: ;
            endcase
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic pop(input logic jmp, input logic [11:0] addr, input logic [31:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            vec++;
            err++;
            $display("FAIL unexpected_output: jmp=%0b addr=%h data=%h required none at %0t", jmp, addr, data, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(jmp), 32'(e.jmp));
            chk("event_addr", 32'(addr), 32'(e.addr));
            chk("event_data", data, e.data);
        end
    endtask
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (idex_csr_we_i) chk("idex_blocks_we", 32'(bus.we), 32'd0);
            if (bus.we) pop(1'b0, bus.addr, bus.wdata);
            if (jump_o) pop(1'b1, bus.addr, jump_addr_o);
        end
    end
    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 0;
        if (a == 12'h300) m_mstatus = d;
        if (a == 12'h305) m_mtvec = d;
        if (a == 12'h341) m_mepc = d;
    endtask
    task automatic clear_req();
        illegal_i = 0; ebreak_i = 0; ecall_i = 0; mret_i = 0;
        ex_irq_i = 0; soft_irq_i = 0; tcmp_irq_i = 0; hx_valid_i = 0; mstatus_mie_i = 0;
    endtask
    task automatic txn(input bit il, eb, ec, mr, ex, sw, tm, hx, mie,
                       input logic [31:0] pc, pcn, inst, input int c, input int s_in, input int rst_at);
        ev_t ev[$];
        int kind, len, n, s, nw;
        bit irq, done;
        logic [31:0] cause, epc, tval, ms, tgt;
        int code;
        irq  = hx && mie && (ex || sw || tm);
        code = ex ? 11 : sw ? 3 : 7;
        kind = (il || eb || ec || (!mr && irq)) ? 1 : mr ? 2 : 0;
        cause = il ? 32'd2 : eb ? 32'd3 : ec ? 32'd11 : 32'h8000_0000 + 32'(code);
        epc   = (il || eb || ec) ? pc : pcn;
        tval  = il ? inst : eb ? pc : 32'd0;
        len = 0;
        if (kind == 1) begin
            ms  = (m_mstatus & ~32'h88) | (m_mstatus[3] ? 32'h80 : 32'h0);
            tgt = (m_mtvec & ~32'h3) + ((cause[31] && m_mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
            ev.push_back('{1'b0, 12'h341, epc});
            ev.push_back('{1'b0, 12'h342, cause});
            ev.push_back('{1'b0, 12'h343, tval});
            ev.push_back('{1'b0, 12'h300, ms});
            ev.push_back('{1'b1, 12'h305, tgt});
            len = 6 + c;
        end else if (kind == 2) begin
            ms = (m_mstatus & ~32'h88) | 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            ev.push_back('{1'b0, 12'h300, ms});
            ev.push_back('{1'b1, 12'h341, m_mepc});
            len = 3 + c;
        end
        s = (s_in > 0) ? s_in : (kind == 2) ? 1 : $urandom_range(1, 4);
        foreach (ev[i]) sb.push_back(ev[i]);
        nw = (rst_at > 0) ? 2 : ev.size();
        for (int i = 0; i < nw; i++) begin
            if (!ev[i].jmp && ev[i].addr == 12'h300) m_mstatus = ev[i].data;
            if (!ev[i].jmp && ev[i].addr == 12'h341) m_mepc = ev[i].data;
            if (!ev[i].jmp && ev[i].addr == 12'h342) m_mcause = ev[i].data;
            if (!ev[i].jmp && ev[i].addr == 12'h343) m_mtval = ev[i].data;
        end
        @(negedge clk);
        illegal_i = il; ebreak_i = eb; ecall_i = ec; mret_i = mr;
        ex_irq_i = ex; soft_irq_i = sw; tcmp_irq_i = tm; hx_valid_i = hx; mstatus_mie_i = mie;
        pc_i = pc; pc_next_i = pcn; inst_i = inst;
        #2;
        chk("hold_accept", 32'(hold_o), 32'(kind != 0));
        if (kind == 0) begin
            @(negedge clk);
            clear_req();
        end else begin
            n = 1;
            done = 0;
            for (int k = 1; k < 64 && !done; k++) begin
                @(negedge clk);
                clear_req();
                idex_csr_we_i = (k >= s && k < s + c);
                if (k == rst_at) rst_n = 0;
                #2;
                if (k == rst_at) begin
                    chk("rst_we", 32'(bus.we), 0);
                    chk("rst_addr", 32'(bus.addr), 0);
                    chk("rst_hold", 32'(hold_o), 0);
                    chk("rst_jump", {jump_o, jump_addr_o[30:0]}, 0);
                    done = 1;
                end else if (!hold_o) done = 1;
                else n++;
            end
            idex_csr_we_i = 0;
            if (rst_at > 0) begin
                chk("abort_pending", 32'(sb.size()), 32'd3);
                sb.delete();
                @(negedge clk);
                rst_n = 1;
                #2;
                chk("post_reset_hold", 32'(hold_o), 0);
            end else begin
                chk("hold_len", 32'(n), 32'(len));
                chk("sb_drained", 32'(sb.size()), 0);
            end
        end
        @(negedge clk);
        chk("csr_mstatus", e_mstatus, m_mstatus);
        chk("csr_mepc", e_mepc, m_mepc);
        chk("csr_mcause", e_mcause, m_mcause);
        chk("csr_mtval", e_mtval, m_mtval);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] t;
        m_mcause = 0; m_mtval = 0;
        ecall_i = 1;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_hold", 32'(hold_o), 0);
        chk("reset_we", 32'(bus.we), 0);
        chk("reset_addr", 32'(bus.addr), 0);
        chk("reset_jump", 32'(jump_o), 0);
        chk("reset_jump_addr", jump_addr_o, 0);
        ecall_i = 0;
        cfg_we = 1; cfg_addr = 12'h342; cfg_data = 0;
        @(negedge clk);
        cfg_addr = 12'h343;
        @(negedge clk);
        cfg_we = 0;
        rst_n = 1;
        set_csr(12'h300, 32'h8);
        set_csr(12'h305, 32'h1000);
        set_csr(12'h341, 32'h0);
        txn(0,0,1,0, 0,0,0, 0,0, 32'h100, 32'h104, 32'h73, 0, 1, 0);
        chk("ecall_mepc", e_mepc, 32'h100);
        chk("ecall_mcause", e_mcause, 32'd11);
        chk("ecall_mstatus", e_mstatus, 32'h80);
        set_csr(12'h305, 32'h1001);
        txn(0,0,0,0, 1,0,1, 1,1, 32'h200, 32'h204, 32'h0, 0, 1, 0);
        chk("irq_mcause", e_mcause, 32'h8000_000B);
        chk("irq_mepc", e_mepc, 32'h204);
        txn(0,0,0,0, 1,1,1, 1,0, 32'h300, 32'h304, 32'h0, 0, 1, 0);
        txn(0,0,0,0, 1,1,1, 0,1, 32'h300, 32'h304, 32'h0, 0, 1, 0);
        txn(0,0,1,0, 0,0,0, 0,0, 32'h400, 32'h404, 32'h0, 2, 2, 0);
        set_csr(12'h300, 32'h80);
        set_csr(12'h341, 32'h300);
        txn(0,0,0,1, 0,0,0, 0,0, 32'h0, 32'h4, 32'h0, 0, 1, 0);
        chk("mret_mstatus", e_mstatus, 32'h88);
        txn(1,1,1,1, 1,1,1, 1,1, 32'h500, 32'h504, 32'hDEAD_BEEF, 0, 1, 0);
        txn(0,1,1,0, 0,0,0, 0,0, 32'h600, 32'h604, 32'h0, 1, 4, 0);
        txn(0,0,1,0, 0,0,0, 0,0, 32'h700, 32'h704, 32'h0, 0, 1, 3);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                t = $urandom;
                t[1] = 1'b0;
                set_csr(12'h305, t);
                set_csr(12'h300, $urandom);
            end
            txn($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom, $urandom, $urandom, $urandom_range(0, 2), 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
